// File: rtl/chan_mux_pkg.sv
// Shared FSM state encoding, mode encoding and next-state rule for chan_mux_seq.
package chan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic state_t next_state(input logic en, input logic mode);
    state_t s;
    if (!en) begin
      s = ST_IDLE;
    end else if (mode == MODE_SCAN) begin
      s = ST_SCAN;
    end else begin
      s = ST_MANUAL;
    end
    return s;
  endfunction

endpackage

// File: rtl/chan_mux_next.sv
// Rotate-priority search: first enabled channel strictly after i_ptr, wrapping,
// so a lone enabled channel finds itself.
module chan_mux_next #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_mask,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic [SEL_W-1:0]    o_next,
  output logic                o_any
);

  localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] w_dbl;
  logic [2*CHANNELS-1:0] w_shift;
  logic [CHANNELS-1:0]   w_rot;
  logic [SEL_W:0]        w_shamt;
  logic [SEL_W:0]        w_sum;
  logic [SEL_W:0]        w_diff;
  logic [SEL_W-1:0]      w_off;

  // Doubled mask shifted so bit 0 of w_rot is the channel just after i_ptr.
  assign w_dbl   = {i_mask, i_mask};
  assign w_shamt = {1'b0, i_ptr} + {{SEL_W{1'b0}}, 1'b1};
  assign w_shift = w_dbl >> w_shamt;
  assign w_rot   = w_shift[CHANNELS-1:0];
  assign o_any   = |i_mask;

  // Lowest set bit of the rotated mask is the distance to the next channel.
  always_comb begin
    w_off = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SEL_W'(k);
      end else begin
        w_off = w_off;
      end
    end
  end

  // Fold the offset back into the 0..CHANNELS-1 range.
  always_comb begin
    w_sum  = w_shamt + {1'b0, w_off};
    w_diff = w_sum - CH_L;
    if (w_sum >= CH_L) begin
      o_next = w_diff[SEL_W-1:0];
    end else begin
      o_next = w_sum[SEL_W-1:0];
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// Channel multiplexer with manual select or masked auto-scan, one-deep
// registered output stage with valid/ready handshake.
module chan_mux_seq
  import chan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CHANNELS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_valid,  w_valid_d;
  logic [WIDTH-1:0] r_data,   w_data_d;
  logic [SEL_W-1:0] r_ch,     w_ch_d;
  logic [SEL_W-1:0] r_ptr,    w_ptr_d;
  logic             r_err,    w_err_d;
  logic [SEL_W-1:0] w_next;
  logic             w_any;
  logic             w_take;
  logic             w_sel_oob;
  logic [WIDTH-1:0] w_chan [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign w_chan[g] = in_data[g*WIDTH +: WIDTH];
  end

  chan_mux_next #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_next (
    .i_mask (chan_en),
    .i_ptr  (r_ptr),
    .o_next (w_next),
    .o_any  (w_any)
  );

  // The output slot may be refilled when empty or being drained this cycle.
  assign w_take    = !r_valid || out_ready;
  assign w_sel_oob = ({1'b0, sel} >= CH_L);

  // Decisions follow the state being entered so en/mode act on the very next edge.
  always_comb begin
    w_state_nxt = next_state(en, mode);
    w_valid_d   = r_valid;
    w_data_d    = r_data;
    w_ch_d      = r_ch;
    w_ptr_d     = r_ptr;
    w_err_d     = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_valid_d = 1'b0;
      end
      ST_MANUAL: begin
        if (w_take) begin
          w_valid_d = 1'b1;
          w_ch_d    = sel;
          if (w_sel_oob) begin
            w_data_d = '0;
            w_err_d  = 1'b1;
          end else begin
            w_data_d = w_chan[sel];
          end
        end else begin
          w_valid_d = r_valid;
        end
      end
      ST_SCAN: begin
        if (r_state != ST_SCAN) begin
          // Entry edge only rewinds the pointer; a held sample keeps waiting.
          w_ptr_d = '0;
          if (out_ready) begin
            w_valid_d = 1'b0;
          end else begin
            w_valid_d = r_valid;
          end
        end else if (w_take) begin
          if (w_any && chan_en[r_ptr]) begin
            w_valid_d = 1'b1;
            w_ch_d    = r_ptr;
            w_data_d  = w_chan[r_ptr];
            w_ptr_d   = w_next;
          end else if (w_any) begin
            w_valid_d = 1'b0;
            w_ptr_d   = w_next;
          end else begin
            w_valid_d = 1'b0;
          end
        end else begin
          w_valid_d = r_valid;
        end
      end
      default: begin
        w_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_ch    <= w_ch_d;
      r_ptr   <= w_ptr_d;
      r_err   <= w_err_d;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Self-checking bench for chan_mux_seq: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_chan_mux_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, out_ready;
  logic [2:0]  sel;
  logic [7:0]  chan_en;
  logic [31:0] in_data;
  logic        out_valid, sel_err;
  logic [3:0]  out_data;
  logic [2:0]  out_ch;

  logic        en6, mode6, rdy6;
  logic [2:0]  sel6;
  logic [5:0]  cen6;
  logic [23:0] d6;
  logic        valid6, err6;
  logic [3:0]  data6;
  logic [2:0]  ch6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chan_mux_seq #(.WIDTH(4), .CHANNELS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .chan_en(chan_en), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .sel_err(sel_err)
  );

  chan_mux_seq #(.WIDTH(4), .CHANNELS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .en(en6), .mode(mode6), .sel(sel6),
    .chan_en(cen6), .in_data(d6), .out_ready(rdy6),
    .out_valid(valid6), .out_data(data6), .out_ch(ch6), .sel_err(err6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_MANUAL = 1, M_SCAN = 2;
  int         m_st    = M_IDLE;
  int         m_ptr   = 0;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;
  logic [3:0] m_data  = 4'd0;
  logic [2:0] m_ch    = 3'd0;

  function automatic int next_en(input logic [7:0] m, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return p;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_ptr <= 0; m_valid <= 1'b0; m_err <= 1'b0;
      m_data <= 4'd0; m_ch <= 3'd0;
    end else begin
      m_err <= 1'b0;
      if (!en) begin
        m_st <= M_IDLE;
        m_valid <= 1'b0;
      end else if (!mode) begin
        m_st <= M_MANUAL;
        if (!m_valid || out_ready) begin
          m_valid <= 1'b1;
          m_ch    <= sel;
          m_data  <= in_data[sel*4 +: 4];
        end
      end else begin
        m_st <= M_SCAN;
        if (m_st != M_SCAN) begin
          m_ptr <= 0;
          if (out_ready) m_valid <= 1'b0;
        end else if (!m_valid || out_ready) begin
          if (chan_en == 8'd0) begin
            m_valid <= 1'b0;
          end else if (chan_en[m_ptr]) begin
            m_valid <= 1'b1;
            m_ch    <= 3'(m_ptr);
            m_data  <= in_data[m_ptr*4 +: 4];
            m_ptr   <= next_en(chan_en, m_ptr);
          end else begin
            m_valid <= 1'b0;
            m_ptr   <= next_en(chan_en, m_ptr);
          end
        end
      end
    end
  end

  // Compare DUT with model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_err", 32'(sel_err), 32'(m_err));
    if (m_valid) begin
      chk("model_data", 32'(out_data), 32'(m_data));
      chk("model_ch", 32'(out_ch), 32'(m_ch));
    end
  end

  // ---------------- stimulus ----------------
  int         exp_c [6] = '{0, 2, 5, 7, 0, 2};
  logic [3:0] exp_d [6] = '{4'h0, 4'h2, 4'hA, 4'h7, 4'h0, 4'h2};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 3'd0; chan_en = 8'd0;
    in_data = 32'h0; out_ready = 1'b0;
    en6 = 1'b0; mode6 = 1'b0; sel6 = 3'd0; cen6 = 6'd0; d6 = 24'h0; rdy6 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);

    // Manual select of channel 5.
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd5;
    in_data = 32'h76A4_3210; out_ready = 1'b1;
    @(negedge clk);
    chk("man_valid", 32'(out_valid), 32'd1);
    chk("man_data", 32'(out_data), 32'hA);
    chk("man_ch", 32'(out_ch), 32'd5);

    // Scan across mask 1010_0101.
    mode = 1'b1; chan_en = 8'hA5;
    @(negedge clk);
    chk("scan_entry_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("scan_valid", 32'(out_valid), 32'd1);
      chk("scan_ch", 32'(out_ch), 32'(exp_c[i]));
      chk("scan_data", 32'(out_data), 32'(exp_d[i]));
    end

    // Backpressure holds channel 2, then channel 5 follows.
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ch", 32'(out_ch), 32'd2);
      chk("stall_data", 32'(out_data), 32'h2);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_ch", 32'(out_ch), 32'd5);

    // Empty mask drains, then a single-channel mask finds channel 4.
    chan_en = 8'h00;
    @(negedge clk);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chan_en = 8'h10;
    @(negedge clk);
    chk("skip_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("one_ch_valid", 32'(out_valid), 32'd1);
    chk("one_ch_ch", 32'(out_ch), 32'd4);
    chk("one_ch_data", 32'(out_data), 32'h4);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_ch", 32'(out_ch), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_ch", 32'(out_ch), 32'd0);
    chk("midrst_err", 32'(sel_err), 32'd0);

    // Dropping en clears valid even while stalled.
    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel = 3'd2; out_ready = 1'b1;
    @(negedge clk);
    chk("man2_ch", 32'(out_ch), 32'd2);
    en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("endrop_valid", 32'(out_valid), 32'd0);

    // Manual sample stalled across a switch to scan completes first.
    en = 1'b1; mode = 1'b0; sel = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    chk("man7_ch", 32'(out_ch), 32'd7);
    out_ready = 1'b0; mode = 1'b1; chan_en = 8'h01;
    @(negedge clk);
    chk("switch_hold_ch", 32'(out_ch), 32'd7);
    chk("switch_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("single_ch", 32'(out_ch), 32'd0);
      chk("single_valid", 32'(out_valid), 32'd1);
    end

    // Six-channel instance: out-of-range manual select.
    en6 = 1'b1; mode6 = 1'b0; sel6 = 3'd7; rdy6 = 1'b1; d6 = 24'hFEDCBA;
    @(negedge clk);
    chk("oob_valid", 32'(valid6), 32'd1);
    chk("oob_data", 32'(data6), 32'd0);
    chk("oob_ch", 32'(ch6), 32'd7);
    chk("oob_err", 32'(err6), 32'd1);
    sel6 = 3'd3;
    @(negedge clk);
    chk("oob_err_clear", 32'(err6), 32'd0);
    chk("ch6_ch", 32'(ch6), 32'd3);
    chk("ch6_data", 32'(data6), 32'hD);
    en6 = 1'b0;

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel     = 3'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0:       chan_en = 8'h00;
        1:       chan_en = 8'h01 << $urandom_range(0, 7);
        2, 3:    chan_en = 8'($urandom);
        default: chan_en = chan_en;
      endcase
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
